instruction_fetch_unit: RTL

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: single-outstanding fetch FSM feeding a prefetch queue
// toward decode, with redirect flush and in-flight response discard.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] QD = CW'(QDEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_imem_req, w_req_nxt;
  logic [31:0]   r_imem_addr, w_addr_nxt;
  logic [31:0]   r_fetch_pc, w_fetch_pc_nxt;
  logic          w_push, w_pop, w_flush;
  logic [31:0]   w_redirect_pc;
  logic [CW-1:0] w_count_after_push;

  logic [31:0]   r_inst [QDEPTH];
  logic [31:0]   r_pcq  [QDEPTH];
  logic [PW-1:0] r_rd_ptr, r_wr_ptr;
  logic [CW-1:0] r_count;

  assign w_redirect_pc      = redirect_pc & 32'hFFFF_FFFC;
  assign w_flush            = redirect;
  assign w_pop              = (r_count != '0) && id_ready && !redirect;
  assign w_count_after_push = w_pop ? r_count : r_count + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_imem_req  <= 1'b0;
      r_imem_addr <= RESET_PC;
      r_fetch_pc  <= RESET_PC;
    end else begin
      r_state     <= w_state_nxt;
      r_imem_req  <= w_req_nxt;
      r_imem_addr <= w_addr_nxt;
      r_fetch_pc  <= w_fetch_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_req_nxt      = r_imem_req;
    w_addr_nxt     = r_imem_addr;
    w_fetch_pc_nxt = r_fetch_pc;
    w_push         = 1'b0;
    case (r_state)
      IDLE: begin
        if (redirect) begin
          w_fetch_pc_nxt = w_redirect_pc;
        end else if (r_count < QD) begin
          w_state_nxt = WAIT;
          w_req_nxt   = 1'b1;
          w_addr_nxt  = r_fetch_pc;
        end
      end
      WAIT: begin
        if (imem_ack && redirect) begin
          // Response dropped; the flushed queue always has room for the new target.
          w_fetch_pc_nxt = w_redirect_pc;
          w_addr_nxt     = w_redirect_pc;
        end else if (imem_ack) begin
          w_push         = 1'b1;
          w_fetch_pc_nxt = r_imem_addr + 32'd4;
          if (w_count_after_push < QD) begin
            w_addr_nxt = r_imem_addr + 32'd4;
          end else begin
            w_state_nxt = IDLE;
            w_req_nxt   = 1'b0;
          end
        end else if (redirect) begin
          w_state_nxt    = DISCARD;
          w_fetch_pc_nxt = w_redirect_pc;
        end
      end
      DISCARD: begin
        if (redirect) w_fetch_pc_nxt = w_redirect_pc;
        if (imem_ack) begin
          w_state_nxt = WAIT;
          w_addr_nxt  = redirect ? w_redirect_pc : r_fetch_pc;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        r_inst[i] <= '0;
        r_pcq[i]  <= '0;
      end
    end else if (w_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_inst[r_wr_ptr] <= imem_rdata;
        r_pcq[r_wr_ptr]  <= r_imem_addr;
        r_wr_ptr         <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign imem_req  = r_imem_req;
  assign imem_addr = r_imem_addr;
  assign id_valid  = (r_count != '0);
  assign id_inst   = r_inst[r_rd_ptr];
  assign id_pc     = r_pcq[r_rd_ptr];

endmodule
